// File: rtl/operand_assembler.sv
// Purpose: gathers bytes from an RX UART stream into NUM_OPS operands of DATA_W bits each.
// Latency: Ops_Valid_out rises one cycle after the last byte of a frame is accepted.
// Backpressure: the full frame is held stable until Ops_Ready_in; bytes arriving meanwhile are dropped.
// Optional inter-byte timeout abort is enabled by defining OPERAND_ASM_TIMEOUT_EN.
module operand_assembler #(
    parameter int DATA_W      = 16,
    parameter int NUM_OPS     = 2,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Start_in,
    input  logic [7:0]                  Rx_Byte_in,
    input  logic                        Rx_Valid_in,
    input  logic                        Ops_Ready_in,
    output logic [NUM_OPS*DATA_W-1:0]   Ops_out,
    output logic                        Ops_Valid_out,
    output logic                        Busy_out,
    output logic                        Timeout_Err_out
);

    localparam int BYTES = DATA_W / 8;
    localparam int BP_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int OP_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                      state;
    logic [BP_W-1:0]             byte_pos;
    logic [OP_W-1:0]             op_idx;
    logic [NUM_OPS*DATA_W-1:0]   ops_r;
    logic                        last_byte;
    logic                        last_op;

    assign last_byte = (byte_pos == BP_W'(BYTES - 1));
    assign last_op   = (op_idx == OP_W'(NUM_OPS - 1));
    assign Ops_out   = ops_r;

`ifdef OPERAND_ASM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] idle_cnt;
    logic            timeout_hit;

    // The abort fires on the TIMEOUT_CYC-th consecutive byte-less cycle.
    assign timeout_hit = (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign Timeout_Err_out = 1'b0;
`endif

    // Frame FSM: byte placement, counters and all registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            byte_pos      <= '0;
            op_idx        <= '0;
            ops_r         <= '0;
            Ops_Valid_out <= 1'b0;
            Busy_out      <= 1'b0;
`ifdef OPERAND_ASM_TIMEOUT_EN
            idle_cnt        <= '0;
            Timeout_Err_out <= 1'b0;
`endif
        end else begin
`ifdef OPERAND_ASM_TIMEOUT_EN
            Timeout_Err_out <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (Start_in) begin
                        state    <= COLLECT;
                        byte_pos <= '0;
                        op_idx   <= '0;
                        Busy_out <= 1'b1;
`ifdef OPERAND_ASM_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (Start_in) begin
                        // Restart: the byte arriving alongside Start is discarded.
                        byte_pos <= '0;
                        op_idx   <= '0;
`ifdef OPERAND_ASM_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end else if (Rx_Valid_in) begin
                        for (int o = 0; o < NUM_OPS; o++) begin
                            for (int j = 0; j < BYTES; j++) begin
                                if (op_idx == OP_W'(o) && byte_pos == BP_W'(j)) begin
                                    ops_r[o*DATA_W + ((MSB_FIRST != 0) ? (DATA_W - 8 - 8*j) : (8*j)) +: 8] <= Rx_Byte_in;
                                end
                            end
                        end
`ifdef OPERAND_ASM_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (last_byte) begin
                            byte_pos <= '0;
                            if (last_op) begin
                                op_idx        <= '0;
                                state         <= HOLD;
                                Ops_Valid_out <= 1'b1;
                            end else begin
                                op_idx <= op_idx + 1'b1;
                            end
                        end else begin
                            byte_pos <= byte_pos + 1'b1;
                        end
                    end
`ifdef OPERAND_ASM_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state           <= IDLE;
                        byte_pos        <= '0;
                        op_idx          <= '0;
                        idle_cnt        <= '0;
                        Busy_out        <= 1'b0;
                        Timeout_Err_out <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (Ops_Ready_in) begin
                        state         <= IDLE;
                        Ops_Valid_out <= 1'b0;
                        Busy_out      <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    Ops_Valid_out <= 1'b0;
                    Busy_out      <= 1'b0;
                end
            endcase
        end
    end

endmodule
